// File: rtl/seg7_score_reader.sv
// Snoops a multiplexed 4-digit 7-segment bus and rebuilds the BCD score and DP bits per frame.
// Optional: define SEG7_READER_HEX_EN to also accept the A-F glyphs as valid digits.
module seg7_score_reader #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 800000,
    parameter int TIMEOUT_WIDTH  = 20
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  SEG_SELECT,
    input  logic [7:0]  DEC_OUT,
    output logic [15:0] SCORE,
    output logic [3:0]  DOTS,
    output logic        SCORE_VALID,
    output logic        SCORE_CHANGED,
    output logic        DECODE_ERR,
    output logic        SEQ_ERR,
    output logic        STALE,
    output logic [1:0]  fsm_state
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_MAX = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

    localparam logic [1:0] HUNT    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [3:0]  s_q, prev_s;
    logic [7:0]  d_q, prev_d;
    logic [SW-1:0] stable_cnt;
    logic        same;
    logic        sel_ok;
    logic [1:0]  cap_digit;
    logic        cap;
    logic [3:0]  nib;
    logic        bad;
    logic [1:0]  state;
    logic [1:0]  expect_digit;
    logic [15:0] work;
    logic [3:0]  work_dots;
    logic        seen_frame;
    logic [TIMEOUT_WIDTH-1:0] tcnt;

    assign same      = ({s_q, d_q} == {prev_s, prev_d});
    assign cap       = same && sel_ok && (stable_cnt == SETTLE_LAST);
    assign STALE     = (tcnt == TIMEOUT_MAX);
    assign fsm_state = state;

    always_comb begin
        sel_ok    = 1'b1;
        cap_digit = 2'd0;
        case (s_q)
            4'b1110: cap_digit = 2'd0;
            4'b1101: cap_digit = 2'd1;
            4'b1011: cap_digit = 2'd2;
            4'b0111: cap_digit = 2'd3;
            default: sel_ok = 1'b0;
        endcase
    end

    // Unknown glyphs become 0xF so a bad digit still yields a complete frame.
    always_comb begin
        nib = 4'hF;
        bad = 1'b0;
        case (d_q[6:0])
            7'b1000000: nib = 4'h0;
            7'b1111001: nib = 4'h1;
            7'b0100100: nib = 4'h2;
            7'b0110000: nib = 4'h3;
            7'b0011001: nib = 4'h4;
            7'b0010010: nib = 4'h5;
            7'b0000010: nib = 4'h6;
            7'b1111000: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0010000: nib = 4'h9;
`ifdef SEG7_READER_HEX_EN
            7'b0001000: nib = 4'hA;
            7'b0000011: nib = 4'hB;
            7'b1000110: nib = 4'hC;
            7'b0100001: nib = 4'hD;
            7'b0000110: nib = 4'hE;
            7'b0001110: nib = 4'hF;
`endif
            default:    bad = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s_q        <= 4'd0;
            d_q        <= 8'd0;
            prev_s     <= 4'd0;
            prev_d     <= 8'd0;
            stable_cnt <= '0;
        end else begin
            s_q    <= SEG_SELECT;
            d_q    <= DEC_OUT;
            prev_s <= s_q;
            prev_d <= d_q;
            if (!same)
                stable_cnt <= '0;
            else if (stable_cnt != SETTLE_MAX)
                stable_cnt <= stable_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= HUNT;
            expect_digit  <= 2'd0;
            work          <= 16'd0;
            work_dots     <= 4'd0;
            seen_frame    <= 1'b0;
            SCORE         <= 16'd0;
            DOTS          <= 4'd0;
            SCORE_VALID   <= 1'b0;
            SCORE_CHANGED <= 1'b0;
            DECODE_ERR    <= 1'b0;
            SEQ_ERR       <= 1'b0;
        end else begin
            SCORE_VALID   <= 1'b0;
            SCORE_CHANGED <= 1'b0;
            SEQ_ERR       <= 1'b0;
            case (state)
                HUNT: begin
                    if (cap && cap_digit == 2'd0) begin
                        work[{cap_digit, 2'b00} +: 4] <= nib;
                        work_dots[cap_digit]          <= ~d_q[7];
                        if (bad) DECODE_ERR <= 1'b1;
                        expect_digit <= 2'd1;
                        state        <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (cap) begin
                        if (cap_digit == expect_digit) begin
                            work[{cap_digit, 2'b00} +: 4] <= nib;
                            work_dots[cap_digit]          <= ~d_q[7];
                            if (bad) DECODE_ERR <= 1'b1;
                            if (expect_digit == 2'd3)
                                state <= DONE;
                            else
                                expect_digit <= expect_digit + 2'd1;
                        end else begin
                            SEQ_ERR <= 1'b1;
                            // A stray digit0 is taken as the start of a fresh frame.
                            if (cap_digit == 2'd0) begin
                                work[{cap_digit, 2'b00} +: 4] <= nib;
                                work_dots[cap_digit]          <= ~d_q[7];
                                if (bad) DECODE_ERR <= 1'b1;
                                expect_digit <= 2'd1;
                            end else begin
                                state <= HUNT;
                            end
                        end
                    end
                end
                DONE: begin
                    SCORE         <= work;
                    DOTS          <= work_dots;
                    SCORE_VALID   <= 1'b1;
                    SCORE_CHANGED <= !seen_frame || (work != SCORE) || (work_dots != DOTS);
                    seen_frame    <= 1'b1;
                    state         <= HUNT;
                end
                default: state <= HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            tcnt <= '0;
        else if (state == DONE)
            tcnt <= '0;
        else if (tcnt != TIMEOUT_MAX)
            tcnt <= tcnt + 1'b1;
    end

endmodule

// File: tb/tb_seg7_score_reader.sv
// Directed bench for seg7_score_reader: a frame-level model checked every cycle plus literal checks.
module tb_seg7_score_reader;

    localparam int SETTLE = 4;
    localparam int TOUT   = 50;
`ifdef SEG7_READER_HEX_EN
    localparam int NDEC = 16;
`else
    localparam int NDEC = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sel = 4'hF;
    logic [7:0]  dec = 8'hFF;
    logic [15:0] score;
    logic [3:0]  dots;
    logic        score_valid, score_changed, decode_err, seq_err, stale;
    logic [1:0]  fsm_state;

    always #5 clk = ~clk;

    seg7_score_reader #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TOUT),
        .TIMEOUT_WIDTH (20)
    ) dut (
        .CLK          (clk),
        .RESET        (rst),
        .SEG_SELECT   (sel),
        .DEC_OUT      (dec),
        .SCORE        (score),
        .DOTS         (dots),
        .SCORE_VALID  (score_valid),
        .SCORE_CHANGED(score_changed),
        .DECODE_ERR   (decode_err),
        .SEQ_ERR      (seq_err),
        .STALE        (stale),
        .fsm_state    (fsm_state)
    );

    logic [6:0] seg_tab [0:15];
    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
    end

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    bit          model_live = 0;
    int          edge_n = 0;
    int          last_v, run_len;
    bit          hunting;
    int          expect_d;
    logic [15:0] m_work, pend_score, held_score;
    logic [3:0]  m_wd, pend_dots, held_dots;
    int          pend_seq_at, pend_done_at, pend_dec_at;
    bit          first_frame;
    int          stale_cnt;
    logic        exp_valid, exp_changed, exp_dec, exp_seq, exp_stale;

    function automatic logic [4:0] model_decode(input logic [6:0] s);
        for (int i = 0; i < NDEC; i++)
            if (seg_tab[i] == s) return {1'b0, 4'(i)};
        return 5'h1F;
    endfunction

    task automatic model_store(input int n, input logic [7:0] d);
        logic [4:0] r;
        r = model_decode(d[6:0]);
        m_work[n*4 +: 4] = r[3:0];
        m_wd[n] = ~d[7];
        if (r[4]) pend_dec_at = edge_n + 1;
    endtask

    task automatic model_capture(input int n, input logic [7:0] d);
        if (hunting) begin
            if (n == 0) begin
                model_store(n, d);
                expect_d = 1;
                hunting = 0;
            end
        end else if (n == expect_d) begin
            model_store(n, d);
            if (n == 3) begin
                pend_done_at = edge_n + 2;
                pend_score = m_work;
                pend_dots = m_wd;
                hunting = 1;
            end else expect_d++;
        end else begin
            pend_seq_at = edge_n + 1;
            if (n == 0) begin
                model_store(n, d);
                expect_d = 1;
            end else hunting = 1;
        end
    endtask

    always @(posedge clk) begin
        int v;
        edge_n++;
        if (rst) begin
            model_live = 1;
            last_v = -1; run_len = 0; hunting = 1; expect_d = 0;
            m_work = 0; m_wd = 0; held_score = 0; held_dots = 0;
            pend_seq_at = -1; pend_done_at = -1; pend_dec_at = -1;
            first_frame = 1; stale_cnt = 0;
            exp_valid = 0; exp_changed = 0; exp_dec = 0; exp_seq = 0; exp_stale = 0;
        end else begin
            exp_valid = 0; exp_changed = 0; exp_seq = 0;
            if (pend_seq_at == edge_n) exp_seq = 1;
            if (pend_dec_at == edge_n) exp_dec = 1;
            if (pend_done_at == edge_n) begin
                exp_valid = 1;
                exp_changed = first_frame || pend_score != held_score || pend_dots != held_dots;
                held_score = pend_score;
                held_dots = pend_dots;
                first_frame = 0;
            end
            if (exp_valid) stale_cnt = 0;
            else if (stale_cnt < TOUT) stale_cnt++;
            exp_stale = (stale_cnt == TOUT);
            v = int'({sel, dec});
            if (v == last_v) run_len++;
            else begin
                run_len = 1;
                last_v = v;
            end
            if (run_len == SETTLE + 1)
                for (int n = 0; n < 4; n++)
                    if (sel == ~(4'b0001 << n)) model_capture(n, dec);
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        logic [26:0] act, exp;
        if (model_live) begin
            act = {score, dots, score_valid, score_changed, decode_err, seq_err, stale};
            exp = {held_score, held_dots, exp_valid, exp_changed, exp_dec, exp_seq, exp_stale};
            checks++;
            if (act === exp) passes++;
            else $display("FAIL cycle %0d outputs: got %h expected %h", edge_n, act, exp);
        end
    end

    // Event monitor for literal frame checks.
    int          n_valid = 0, n_seq = 0;
    logic [15:0] last_score = 0;
    logic [3:0]  last_dots = 0;
    logic        last_changed = 0, last_stale = 0;
    always @(negedge clk) begin
        if (score_valid) begin
            n_valid++;
            last_score = score;
            last_dots = dots;
            last_changed = score_changed;
            last_stale = stale;
        end
        if (seq_err) n_seq++;
    end

    // ---------------- drivers ----------------
    task automatic hold(input logic [3:0] s, input logic [7:0] d, input int cyc);
        sel = s;
        dec = d;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic drive_slot(input int n, input int val, input logic dp, input int cyc);
        logic [3:0] s;
        s = ~(4'b0001 << n);
        hold(s, {~dp, seg_tab[val]}, cyc);
    endtask

    task automatic drive_frame(input logic [15:0] sc, input logic [3:0] dp, input int cyc);
        for (int d = 0; d < 4; d++) drive_slot(d, int'(sc[d*4 +: 4]), dp[d], cyc);
        hold(4'hF, 8'hFF, 4);
    endtask

    task automatic glitch_frame(input logic [15:0] sc);
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < SETTLE - 1; k++)
                drive_slot(d, (int'(sc[d*4 +: 4]) + k + 1) % 10, 1'b0, 1);
            drive_slot(d, int'(sc[d*4 +: 4]), 1'b0, 10);
        end
        hold(4'hF, 8'hFF, 4);
    endtask

    task automatic settle_check();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int bv, bs;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        settle_check();
        check("reset_score", 32'(score), 32'h0);
        check("reset_flags", 32'({score_valid, decode_err, seq_err, stale}), 32'h0);
        check("reset_state_hunt", 32'(fsm_state), 32'h0);

        // Score 0123 with DP on digit2, then the identical frame again.
        bv = n_valid;
        drive_frame(16'h0123, 4'b0100, 10);
        settle_check();
        check("f1_count", 32'(n_valid - bv), 32'd1);
        check("f1_score", 32'(last_score), 32'h0123);
        check("f1_dots", 32'(last_dots), 32'b0100);
        check("f1_changed", 32'(last_changed), 32'd1);
        bv = n_valid;
        drive_frame(16'h0123, 4'b0100, 10);
        settle_check();
        check("f2_count", 32'(n_valid - bv), 32'd1);
        check("f2_unchanged", 32'(last_changed), 32'd0);

        // Short glitches before each stable slot.
        bv = n_valid;
        glitch_frame(16'h4567);
        settle_check();
        check("glitch_count", 32'(n_valid - bv), 32'd1);
        check("glitch_score", 32'(last_score), 32'h4567);

        // Segments toggling every 2 cycles never settle.
        bv = n_valid;
        for (int k = 0; k < 20; k++) hold(4'b1110, {1'b1, seg_tab[k % 10]}, 2);
        hold(4'hF, 8'hFF, 4);
        settle_check();
        check("toggle_no_valid", 32'(n_valid - bv), 32'd0);

        // Out-of-order 0,1,3 then a clean frame.
        bv = n_valid;
        bs = n_seq;
        drive_slot(0, 1, 1'b0, 10);
        drive_slot(1, 2, 1'b0, 10);
        drive_slot(3, 3, 1'b0, 10);
        hold(4'hF, 8'hFF, 4);
        settle_check();
        check("seq_err_pulse", 32'(n_seq - bs), 32'd1);
        check("seq_no_valid", 32'(n_valid - bv), 32'd0);
        bv = n_valid;
        drive_frame(16'h9876, 4'b0000, 10);
        settle_check();
        check("seq_recover_count", 32'(n_valid - bv), 32'd1);
        check("seq_recover_score", 32'(last_score), 32'h9876);
        check("seq_recover_changed", 32'(last_changed), 32'd1);

        // Glyph 'A' on digit1.
        bv = n_valid;
        drive_frame(16'h31A5, 4'b0000, 10);
        settle_check();
        check("hex_count", 32'(n_valid - bv), 32'd1);
`ifdef SEG7_READER_HEX_EN
        check("hex_score", 32'(last_score), 32'h31A5);
        check("hex_decode_err", 32'(decode_err), 32'd0);
`else
        check("hex_score", 32'(last_score), 32'h31F5);
        check("hex_decode_err", 32'(decode_err), 32'd1);
`endif

        // Idle display until STALE, then a clean frame clears it.
        hold(4'hF, 8'hFF, TOUT + 5);
        settle_check();
        check("stale_set", 32'(stale), 32'd1);
        bv = n_valid;
        drive_frame(16'h0042, 4'b0001, 10);
        settle_check();
        check("stale_frame_count", 32'(n_valid - bv), 32'd1);
        check("stale_clear_at_valid", 32'(last_stale), 32'd0);
`ifdef SEG7_READER_HEX_EN
        check("decode_err_sticky", 32'(decode_err), 32'd0);
`else
        check("decode_err_sticky", 32'(decode_err), 32'd1);
`endif

        // One-cycle reset in the middle of the digit2 slot.
        bv = n_valid;
        drive_slot(0, 7, 1'b0, 10);
        drive_slot(1, 7, 1'b0, 10);
        drive_slot(2, 7, 1'b0, 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_score", 32'(score), 32'h0);
        check("midrst_flags", 32'({dots, score_valid, decode_err, seq_err, stale}), 32'h0);
        check("midrst_state_hunt", 32'(fsm_state), 32'h0);
        drive_slot(2, 7, 1'b0, 6);
        drive_slot(3, 0, 1'b0, 10);
        hold(4'hF, 8'hFF, 4);
        settle_check();
        check("midrst_no_valid", 32'(n_valid - bv), 32'd0);
        bv = n_valid;
        drive_frame(16'h0777, 4'b0000, 10);
        settle_check();
        check("midrst_new_count", 32'(n_valid - bv), 32'd1);
        check("midrst_new_score", 32'(last_score), 32'h0777);
        check("midrst_new_changed", 32'(last_changed), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
